// File: rtl/wb_blkregs_param.sv
//-----------------------------------------------------------------------------
// wb_blkregs_param
//
// Bank of NUM_REGS read/write control registers behind a Wishbone pipelined
// slave. It has byte-lane write enables, a per-bit implemented-field mask
// (RW_MASK) and a one-cycle write strobe per register. It uses the wr-in /
// rd-out pipelining scheme:
//   write: request registered (cycle 0), decode + update (cycle 1),
//          response (cycle 2)
//   read : combinational decode (cycle 0), data + response (cycle 1)
// Only one transaction is outstanding at a time.
//
// Optional feature (compile-time macro WB_BLKREGS_ERR_EN):
//   defined   - an access to an unmapped word address (>= NUM_REGS) is
//               answered with wb_err_o instead of wb_ack_o
//   undefined - unmapped accesses are acked (reads return 0) and wb_err_o
//               stays 0
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_n_i      synchronous active-low reset
//   wb_cyc_i     Wishbone cycle
//   wb_stb_i     Wishbone strobe
//   wb_adr_i     word address (byte address bits [ADR_W+1:2])
//   wb_sel_i     byte-lane select
//   wb_we_i      write enable
//   wb_dat_i     write data
//   wb_ack_o     acknowledge (one cycle per request)
//   wb_err_o     error response for unmapped accesses (see macro above)
//   wb_rty_o     retry, always 0
//   wb_stall_o   stall, high while a request waits for its response
//   wb_dat_o     read data
//   regs_o       current register values, register i at [i*DATA_W +: DATA_W]
//   wstb_o       one-cycle write strobe per register
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module wb_blkregs_param #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 32,
    parameter logic [NUM_REGS*DATA_W-1:0] RW_MASK = {(NUM_REGS*DATA_W){1'b1}},
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0,
    localparam int ADR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic [ADR_W+1:2]             wb_adr_i,
    input  logic [DATA_W/8-1:0]          wb_sel_i,
    input  logic                         wb_we_i,
    input  logic [DATA_W-1:0]            wb_dat_i,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         wb_rty_o,
    output logic                         wb_stall_o,
    output logic [DATA_W-1:0]            wb_dat_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wstb_o
);

`ifdef WB_BLKREGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int NSEL = DATA_W / 8;

    // Bus request decode
    logic en;
    logic idle;
    logic wr_accept;
    logic rd_accept;
    logic resp;

    // Transaction flags and wr-in stage
    logic                wip_q, wip_d;
    logic                rip_q, rip_d;
    logic                wr_req_q;
    logic [ADR_W-1:0]    wr_adr_q;
    logic [DATA_W-1:0]   wr_dat_q;
    logic [NSEL-1:0]     wr_sel_q;

    // rd-out stage / response
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;

    // Register storage; only implemented bits are ever non-zero
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic [NUM_REGS-1:0] wr_hit;
    logic                wr_mapped;
    logic [DATA_W-1:0]   wr_bmask;
    logic                rd_mapped;
    logic [DATA_W-1:0]   rd_data;

    assign en   = wb_cyc_i & wb_stb_i;
    assign resp = ack_q | err_q;
    // Accepting only when nothing is in flight keeps a single outstanding
    // request even if wb_we_i changes while a request is being stalled.
    assign idle      = ~wip_q & ~rip_q;
    assign wr_accept = en &  wb_we_i & idle;
    assign rd_accept = en & ~wb_we_i & idle;

    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = en & ~resp;
    assign wb_dat_o   = rdat_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // No index matches an unmapped address, so such writes hit nothing.
            assign wr_hit[gi] = wr_req_q & (int'(wr_adr_q) == gi);
            assign regs_o[gi*DATA_W +: DATA_W] = regs_q[gi];
        end
        for (gi = 0; gi < NSEL; gi++) begin : g_lane
            assign wr_bmask[gi*8 +: 8] = {8{wr_sel_q[gi]}};
        end
    endgenerate

    assign wr_mapped = |wr_hit;
    // A write caught by reset in its decode cycle never lands, so it must
    // not strobe either.
    assign wstb_o = wr_hit & {NUM_REGS{rst_n_i}};

    // Read decode: stored values are already masked, so unimplemented bits
    // read 0; unmapped addresses read 0.
    always_comb begin
        rd_data   = '0;
        rd_mapped = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(wb_adr_i) == i) begin
                rd_data   = regs_q[i];
                rd_mapped = 1'b1;
            end
        end
    end

    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rdat_d = rdat_q;
        wip_d  = wip_q;
        rip_d  = rip_q;
        // The response cycle retires whichever transaction was in flight.
        if (resp) begin
            wip_d = 1'b0;
            rip_d = 1'b0;
        end
        if (wr_accept) begin
            wip_d = 1'b1;
        end
        if (rd_accept) begin
            rip_d  = 1'b1;
            rdat_d = rd_data;
            if (rd_mapped || !ERR_EN) begin
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (wr_req_q) begin
            if (wr_mapped || !ERR_EN) begin
                ack_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wip_q    <= 1'b0;
            rip_q    <= 1'b0;
            wr_req_q <= 1'b0;
            wr_adr_q <= '0;
            wr_dat_q <= '0;
            wr_sel_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W] & RW_MASK[i*DATA_W +: DATA_W];
            end
        end else begin
            wip_q    <= wip_d;
            rip_q    <= rip_d;
            wr_req_q <= wr_accept;
            if (wr_accept) begin
                wr_adr_q <= wb_adr_i;
                wr_dat_q <= wb_dat_i;
                wr_sel_q <= wb_sel_i;
            end
            ack_q  <= ack_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    regs_q[i] <= (regs_q[i] & ~(wr_bmask & RW_MASK[i*DATA_W +: DATA_W]))
                               | (wr_dat_q &  (wr_bmask & RW_MASK[i*DATA_W +: DATA_W]));
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_blkregs_param.sv
`timescale 1ns/1ps

module tb_wb_blkregs_param;

`ifdef WB_BLKREGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc, stb, we, tgt;
    logic [1:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    // dut4: 4 registers, reg1 resets to 0xA5, reg3 implements 0x17 only
    logic         ack4, err4, rty4, stall4;
    logic [31:0]  dat4;
    logic [127:0] regs4;
    logic [3:0]   wstb4;
    // dut3: 3 registers, address 3 unmapped
    logic         ack3, err3, rty3, stall3;
    logic [31:0]  dat3;
    logic [95:0]  regs3;
    logic [2:0]   wstb3;

    wb_blkregs_param #(
        .NUM_REGS (4),
        .DATA_W   (32),
        .RW_MASK  ({32'h0000_0017, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}),
        .RST_VAL  ({32'h0, 32'h0, 32'h0000_00A5, 32'h0})
    ) dut4 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_cyc_i   (cyc & ~tgt),
        .wb_stb_i   (stb & ~tgt),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_dat_i   (dat),
        .wb_ack_o   (ack4),
        .wb_err_o   (err4),
        .wb_rty_o   (rty4),
        .wb_stall_o (stall4),
        .wb_dat_o   (dat4),
        .regs_o     (regs4),
        .wstb_o     (wstb4)
    );

    wb_blkregs_param #(
        .NUM_REGS (3),
        .DATA_W   (32)
    ) dut3 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_cyc_i   (cyc & tgt),
        .wb_stb_i   (stb & tgt),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_dat_i   (dat),
        .wb_ack_o   (ack3),
        .wb_err_o   (err3),
        .wb_rty_o   (rty3),
        .wb_stall_o (stall3),
        .wb_dat_o   (dat3),
        .regs_o     (regs3),
        .wstb_o     (wstb3)
    );

    // View of the currently targeted instance
    logic        ack, err, stall;
    logic [31:0] rdat;
    logic [3:0]  wstb;
    assign ack   = tgt ? ack3   : ack4;
    assign err   = tgt ? err3   : err4;
    assign stall = tgt ? stall3 : stall4;
    assign rdat  = tgt ? dat3   : dat4;
    assign wstb  = tgt ? {1'b0, wstb3} : wstb4;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          exp_cyc;
        bit          exp_err;
        bit          is_rd;
        logic [31:0] exp_dat;
    } sb_t;
    sb_t sbq[$];

    // Reference register contents, [instance][register]
    logic [31:0] mdl [2][4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input bit t, input int i);
        return (!t && i == 3) ? 32'h0000_0017 : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rst_of(input bit t, input int i);
        return (!t && i == 1) ? 32'h0000_00A5 : 32'h0;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 4; i++)
                mdl[t][i] = rst_of(t[0], i) & mask_of(t[0], i);
    endtask

    // One bus transaction; 'drop' releases cyc/stb right after the accept cycle.
    task automatic txn(input bit t, input bit w, input logic [1:0] a,
                       input logic [3:0] s, input logic [31:0] d, input bit drop);
        sb_t         it;
        bit          mapped;
        bit          seen;
        logic [3:0]  exp_wstb;
        logic [3:0]  wacc;
        int          npulse;
        logic [31:0] bm;
        logic [31:0] m;

        mapped     = !t || (a != 2'd3);
        it.exp_cyc = cyc_cnt + (w ? 2 : 1);
        it.exp_err = !mapped && ERR_EN;
        it.is_rd   = !w;
        it.exp_dat = mapped ? mdl[t][a] : 32'h0;
        sbq.push_back(it);
        exp_wstb = (w && mapped) ? (4'b0001 << a) : 4'b0000;
        if (w && mapped) begin
            bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            m  = bm & mask_of(t, int'(a));
            mdl[t][a] = (mdl[t][a] & ~m) | (d & m);
        end

        tgt = t; we = w; adr = a; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        #1 chk("stall_req", stall, 1);

        wacc = '0; npulse = 0; seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (drop) begin cyc = 1'b0; stb = 1'b0; end
            if (wstb != 4'b0) npulse++;
            wacc |= wstb;
            if (ack || err) seen = 1'b1;
        end
        if (!seen) begin
            chk("resp_timeout", 0, 1);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else begin
            it = sbq.pop_front();
            chk("latency", cyc_cnt, it.exp_cyc);
            chk("ack", ack, !it.exp_err);
            chk("err", err, it.exp_err);
            chk("stall_resp", stall, 0);
            if (it.is_rd) chk("rdata", rdat, it.exp_dat);
        end
        $display("txn tgt=%0d we=%0d adr=%0d sel=%b wdat=%h rdat=%h ack=%0d err=%0d wstb=%b cyc=%0d",
                 t, w, a, s, d, rdat, ack, err, wacc, cyc_cnt);
        cyc = 1'b0; stb = 1'b0;
        chk("wstb_val", wacc, exp_wstb);
        chk("wstb_cnt", npulse, (exp_wstb != 4'b0) ? 1 : 0);
        @(negedge clk);
        chk("resp_once", ack | err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ra;
        logic [3:0]  rs;
        logic [31:0] rd;

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; tgt = 1'b0;
        adr = '0; sel = '0; dat = '0;
        model_reset();

        // Reset state after one clock with reset asserted
        @(negedge clk);
        chk("rst_reg0", regs4[31:0], 32'h0);
        chk("rst_reg1", regs4[63:32], 32'h0000_00A5);
        chk("rst_reg23", regs4[127:64], 64'h0);
        chk("rst_regs3", regs3[63:0], 64'h0);
        chk("rst_resp4", {ack4, err4, wstb4}, 0);
        chk("rst_resp3", {ack3, err3, wstb3}, 0);
        chk("rst_dat", dat4, 0);
        chk("rty", {rty4, rty3}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-word write and read back
        txn(0, 1, 2'd2, 4'hF, 32'hDEAD_BEEF, 0);
        chk("reg2_out", regs4[95:64], 32'hDEAD_BEEF);
        txn(0, 0, 2'd2, 4'hF, 32'h0, 0);
        // sel = 0 still strobes, data unchanged
        txn(0, 1, 2'd2, 4'h0, 32'h1234_5678, 0);
        chk("reg2_sel0", regs4[95:64], 32'hDEAD_BEEF);
        txn(0, 0, 2'd2, 4'hF, 32'h0, 0);

        // Byte lanes
        txn(0, 1, 2'd0, 4'b0101, 32'h1122_3344, 0);
        chk("reg0_lanes", regs4[31:0], 32'h0022_0044);
        txn(0, 0, 2'd0, 4'hF, 32'h0, 0);

        // Implemented-field mask
        txn(0, 1, 2'd3, 4'hF, 32'hFFFF_FFFF, 0);
        chk("reg3_mask", regs4[127:96], 32'h0000_0017);
        txn(0, 0, 2'd3, 4'hF, 32'h0, 0);

        // Reset value readback, then write with cyc dropped after accept
        txn(0, 0, 2'd1, 4'hF, 32'h0, 0);
        txn(0, 1, 2'd1, 4'hF, 32'h1234_5678, 1);
        chk("reg1_drop", regs4[63:32], 32'h1234_5678);

        // Unmapped address on the 3-register instance
        txn(1, 1, 2'd3, 4'hF, 32'h55AA_55AA, 0);
        txn(1, 0, 2'd3, 4'hF, 32'h0, 0);
        txn(1, 1, 2'd2, 4'b0011, 32'hA1B2_C3D4, 0);
        txn(1, 0, 2'd2, 4'hF, 32'h0, 0);
        txn(1, 0, 2'd0, 4'hF, 32'h0, 0);
        chk("regs3_after", regs3, {32'h0000_C3D4, 32'h0, 32'h0});

        // Reset during the decode cycle of a write to reg1
        tgt = 1'b0; we = 1'b1; adr = 2'd1; sel = 4'hF; dat = 32'hCAFE_F00D;
        cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_reg1", regs4[63:32], 32'h0000_00A5);
        chk("midrst_reg2", regs4[95:64], 32'h0);
        for (int n = 0; n < 3; n++) begin
            chk("midrst_noresp", ack4 | err4, 0);
            chk("midrst_nowstb", wstb4, 0);
            chk("midrst_stall", stall4, 0);
            @(negedge clk);
        end
        txn(0, 0, 2'd1, 4'hF, 32'h0, 0);

        // Random writes with read-back on the 4-register instance
        for (int k = 0; k < 6; k++) begin
            ra = 2'($urandom_range(0, 3));
            rs = 4'($urandom_range(0, 15));
            rd = $urandom;
            txn(0, 1, ra, rs, rd, 0);
            txn(0, 0, ra, 4'hF, 32'h0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
